boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 169 ++++++++++++++++
 tb/tb_boot_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot loader: streams program words into instruction memory one byte per cycle, then
// sequences CPU reset, a bounded run window and halt. Define BOOT_LOADER_CLEAR_EN to zero-fill memory after the last word.
module boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_BYTES = 4,
  parameter int RST_CYCLES = 2,
  parameter int RUN_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [8*WORD_BYTES-1:0] load_data,
  input  logic                    load_last,
  output logic                    imem_we,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [7:0]              imem_wdata,
  output logic                    cpu_rst,
  output logic                    running,
  output logic                    done
);
  localparam int CNT_MAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BC_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SPLIT,
    S_BOOT,
    S_RUN,
`ifdef BOOT_LOADER_CLEAR_EN
    S_HALT,
    S_CLEAR
`else
    S_HALT
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BC_W-1:0]         bcnt_q, bcnt_d;
  logic                    last_q, last_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
    end
  end

  // Word shift register: the low byte is always the next byte to write.
  always_ff @(posedge clock) begin
    word_q <= word_d;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          word_d  = load_data;
          last_d  = load_last;
          bcnt_d  = '0;
          state_d = S_SPLIT;
        end
      end
      S_SPLIT: begin
        word_d = word_q >> 8;
        ptr_d  = ptr_q + ADDR_WIDTH'(1);
        bcnt_d = bcnt_q + BC_W'(1);
        if (bcnt_q == BC_LAST) begin
          cnt_d = '0;
          if (!last_q) state_d = S_LOAD;
`ifdef BOOT_LOADER_CLEAR_EN
          else if (ptr_d != '0) state_d = S_CLEAR;
`endif
          else state_d = S_BOOT;
        end
      end
`ifdef BOOT_LOADER_CLEAR_EN
      S_CLEAR: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == '1) begin
          state_d = S_BOOT;
          cnt_d   = '0;
        end
      end
`endif
      S_BOOT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == BOOT_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == RUN_LAST) begin
          state_d = S_HALT;
          cnt_d   = '0;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    cpu_rst    = 1'b1;
    running    = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_LOAD: load_ready = 1'b1;
      S_SPLIT: begin
        imem_we    = 1'b1;
        imem_addr  = ptr_q;
        imem_wdata = word_q[7:0];
      end
`ifdef BOOT_LOADER_CLEAR_EN
      S_CLEAR: begin
        imem_we   = 1'b1;
        imem_addr = ptr_q;
      end
`endif
      S_RUN: begin
        cpu_rst = 1'b0;
        running = 1'b1;
      end
      S_HALT: done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: a cycle table for the first session, then sessions of random
// words checked against a byte-stream model on a default instance and a 3-bit-address instance.
module tb_boot_loader;
  localparam int AW_A = 10, RST_A = 2, RUN_A = 64;
  localparam int AW_B = 3,  RST_B = 1, RUN_B = 3;

  logic clock = 1'b0, rst = 1'b1, start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic a_load_ready, a_imem_we, a_cpu_rst, a_running, a_done;
  logic [AW_A-1:0] a_imem_addr;
  logic [7:0] a_imem_wdata;
  logic b_load_ready, b_imem_we, b_cpu_rst, b_running, b_done;
  logic [AW_B-1:0] b_imem_addr;
  logic [7:0] b_imem_wdata;

  int vec_cnt = 0, miss_cnt = 0;
  int act_a[$], act_b[$], exp_a[$], exp_b[$];
  int a_run_cnt = 0, b_run_cnt = 0, a_gap = 0, b_gap = 0, a_boot_len = -1, b_boot_len = -1;
  logic a_run_prev = 1'b0, b_run_prev = 1'b0;
  logic [31:0] words[8];

  typedef struct packed {
    logic rst, start, valid;
    logic [31:0] data;
    logic last;
    logic [22:0] exp;
  } vec_t;
  vec_t tbl[$];

  boot_loader #(.ADDR_WIDTH(AW_A), .WORD_BYTES(4), .RST_CYCLES(RST_A), .RUN_CYCLES(RUN_A)) u_a (
    .clock(clock), .rst(rst), .start(start), .load_valid(load_valid), .load_ready(a_load_ready),
    .load_data(load_data), .load_last(load_last), .imem_we(a_imem_we), .imem_addr(a_imem_addr),
    .imem_wdata(a_imem_wdata), .cpu_rst(a_cpu_rst), .running(a_running), .done(a_done));

  boot_loader #(.ADDR_WIDTH(AW_B), .WORD_BYTES(4), .RST_CYCLES(RST_B), .RUN_CYCLES(RUN_B)) u_b (
    .clock(clock), .rst(rst), .start(start), .load_valid(load_valid), .load_ready(b_load_ready),
    .load_data(load_data), .load_last(load_last), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
    .imem_wdata(b_imem_wdata), .cpu_rst(b_cpu_rst), .running(b_running), .done(b_done));

  always #5 clock = ~clock;

  // Write log and boot/run length measurement, sampled mid-cycle.
  always @(negedge clock) begin
    if (a_imem_we) begin
      act_a.push_back(int'({a_imem_addr, a_imem_wdata}));
      a_gap <= 0;
    end else if (!a_running) a_gap <= a_gap + 1;
    if (a_running) a_run_cnt <= a_run_cnt + 1;
    if (a_running && !a_run_prev) a_boot_len <= a_gap;
    a_run_prev <= a_running;
  end

  always @(negedge clock) begin
    if (b_imem_we) begin
      act_b.push_back(int'({b_imem_addr, b_imem_wdata}));
      b_gap <= 0;
    end else if (!b_running) b_gap <= b_gap + 1;
    if (b_running) b_run_cnt <= b_run_cnt + 1;
    if (b_running && !b_run_prev) b_boot_len <= b_gap;
    b_run_prev <= b_running;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [31:0] d,
                              input logic l, input logic rdy, input logic we, input logic [9:0] ad,
                              input logic [7:0] wd, input logic cr, input logic rn, input logic dn);
    vec_t t;
    t.rst = r; t.start = s; t.valid = v; t.data = d; t.last = l;
    t.exp = {rdy, we, ad, wd, cr, rn, dn};
    return t;
  endfunction

  // Expected byte stream: little-endian bytes at consecutive wrapping addresses, then optional zero fill.
  function automatic void build_exp(input int n);
    int sz, p, e;
    exp_a.delete();
    exp_b.delete();
    for (int s = 0; s < 2; s++) begin
      sz = 1 << ((s == 0) ? AW_A : AW_B);
      p = 0;
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          e = ((p % sz) << 8) | int'((words[i] >> (8 * k)) & 32'hFF);
          if (s == 0) exp_a.push_back(e); else exp_b.push_back(e);
          p++;
        end
      end
`ifdef BOOT_LOADER_CLEAR_EN
      if (p % sz != 0) begin
        for (int q = p % sz; q < sz; q++) begin
          if (s == 0) exp_a.push_back(q << 8); else exp_b.push_back(q << 8);
        end
      end
`endif
    end
  endfunction

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!(a_done && b_done) && c < 4000) begin
      @(negedge clock);
      c++;
    end
    #1;
    chk(name, {a_done, b_done}, 2'b11);
  endtask

  task automatic run_session(input int n, input bit stray);
    int base_a, base_b, run_a0, run_b0, gap;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1;
    base_a = act_a.size(); base_b = act_b.size();
    run_a0 = a_run_cnt;    run_b0 = b_run_cnt;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock); start = stray && (i > 0); load_valid = 1'b0;
      end
      @(negedge clock); start = 1'b0; load_valid = 1'b1; load_data = words[i]; load_last = (i == n - 1);
      #1;
      chk("ready", {a_load_ready, b_load_ready}, 2'b11);
      if (i == 0) chk("restart", {a_done, a_cpu_rst, b_done}, 3'b010);
      for (int k = 0; k < 4; k++) begin
        @(negedge clock); load_valid = 1'b0; load_last = 1'b0; start = stray; load_data = $urandom;
        #1;
        chk("split_ready", {a_load_ready, b_load_ready, a_imem_we, b_imem_we}, 4'b0011);
      end
    end
    @(negedge clock); start = 1'b0;
    wait_done("sess_done");
    build_exp(n);
    chk("a_nwr", act_a.size() - base_a, exp_a.size());
    chk("b_nwr", act_b.size() - base_b, exp_b.size());
    for (int i = 0; i < exp_a.size() && base_a + i < act_a.size(); i++)
      chk($sformatf("a_wr[%0d]", i), act_a[base_a + i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && base_b + i < act_b.size(); i++)
      chk($sformatf("b_wr[%0d]", i), act_b[base_b + i], exp_b[i]);
    chk("a_boot", a_boot_len, RST_A);
    chk("b_boot", b_boot_len, RST_B);
    chk("a_run", a_run_cnt - run_a0, RUN_A);
    chk("b_run", b_run_cnt - run_b0, RUN_B);
    repeat (3) @(negedge clock);
    #1;
    chk("halt_outs", {a_done, a_cpu_rst, a_running, b_done, b_cpu_rst, b_running}, 6'b110110);
  endtask

  initial begin
    int base_a;
    rst = 1'b1;
    repeat (3) @(negedge clock);

    tbl.push_back(mk(1, 0, 0, 32'h0, 0,        0, 0, 10'd0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0,        0, 0, 10'd0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h00C18193, 1, 1, 0, 10'd0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0,        0, 1, 10'd0, 8'h93, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0,        0, 1, 10'd1, 8'h81, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0,        0, 1, 10'd2, 8'hC1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0,        0, 1, 10'd3, 8'h00, 1, 0, 0));
`ifdef BOOT_LOADER_CLEAR_EN
    tbl.push_back(mk(0, 1, 0, 32'h0, 0,        0, 1, 10'd4, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0,        0, 1, 10'd5, 8'h00, 1, 0, 0));
`else
    tbl.push_back(mk(0, 1, 0, 32'h0, 0,        0, 0, 10'd0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0, 0,        0, 0, 10'd0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0, 0,        0, 0, 10'd0, 8'h00, 0, 1, 0));
`endif
    foreach (tbl[i]) begin
      @(negedge clock);
      rst = tbl[i].rst; start = tbl[i].start; load_valid = tbl[i].valid;
      load_data = tbl[i].data; load_last = tbl[i].last;
      #1;
      chk($sformatf("tbl%0d", i),
          {a_load_ready, a_imem_we, a_imem_addr, a_imem_wdata, a_cpu_rst, a_running, a_done}, tbl[i].exp);
    end
    @(negedge clock);
    start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    wait_done("tbl_done");
    chk("tbl_boot", a_boot_len, RST_A);
    chk("tbl_run", a_run_cnt, RUN_A);

    words[0] = 32'h03020100; words[1] = 32'h07060504; words[2] = 32'hDDCCBBAA;
    run_session(3, 1'b0);

    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      run_session($urandom_range(1, 6), s[0]);
    end

    // Reset on the second byte of a word aborts it.
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1;
    base_a = act_a.size();
    @(negedge clock); start = 1'b0; load_valid = 1'b1; load_data = 32'h11223344; load_last = 1'b1;
    @(negedge clock); load_valid = 1'b0; load_last = 1'b0;
    #1;
    chk("rst_byte0", {a_imem_we, a_imem_addr, a_imem_wdata}, {1'b1, 10'd0, 8'h44});
    @(negedge clock); rst = 1'b1;
    #1;
    chk("rst_byte1", {a_imem_we, a_imem_addr, a_imem_wdata}, {1'b1, 10'd1, 8'h33});
    @(negedge clock); rst = 1'b0;
    #1;
    chk("rst_outs", {a_load_ready, a_imem_we, a_imem_addr, a_imem_wdata, a_cpu_rst, a_running, a_done},
        {1'b0, 1'b0, 10'd0, 8'd0, 1'b1, 1'b0, 1'b0});
    repeat (4) @(negedge clock);
    #1;
    chk("rst_nwr", act_a.size() - base_a, 2);
    chk("rst_idle", {a_imem_we, a_running, a_done, a_cpu_rst, b_imem_we, b_running}, 6'b000100);

    for (int i = 0; i < 8; i++) words[i] = $urandom;
    run_session(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end
endmodule
